// File: rtl/onehot_rr_arbiter.sv
// Round-robin feeder for a 3-way one-hot registered mux. It holds one buffered
// word per source, grants one slot per cycle, and flags the mux output one cycle later.
module onehot_rr_arbiter #(
  parameter int WIDTH = 16,
  parameter int N     = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_valid,
  input  logic [WIDTH-1:0] req_data [N-1:0],
  output logic [N-1:0]     req_ready,
  input  logic             stall,
  output logic [WIDTH-1:0] mux_in [N-1:0],
  output logic [N-1:0]     mux_en,
  output logic             out_valid
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]     r_slot_v;
  logic [WIDTH-1:0] r_slot_d [N-1:0];
  logic [PW-1:0]    r_ptr;
  logic             r_out_valid;

  logic [N-1:0]     w_grant;
  logic [PW-1:0]    w_gidx;
  logic [PW-1:0]    w_ptr_nxt;

  // Grant selection: first valid slot scanning from ptr with wrap. Gated by
  // reset as well as stall so nothing is offered to the mux while resetting.
  always_comb begin : p_grant
    int   idx;
    logic found;
    w_grant = '0;
    w_gidx  = '0;
    found   = 1'b0;
    idx     = 0;
    if (!rst && !stall && (|r_slot_v)) begin
      for (int k = 0; k < N; k++) begin
        idx = int'(r_ptr) + k;
        if (idx >= N) begin
          idx = idx - N;
        end else begin
          idx = idx;
        end
        if (!found && r_slot_v[idx[PW-1:0]]) begin
          found                 = 1'b1;
          w_grant[idx[PW-1:0]]  = 1'b1;
          w_gidx                = idx[PW-1:0];
        end else begin
          found = found;
        end
      end
    end else begin
      w_grant = '0;
    end
  end

  // Pointer advance: one past the granted slot, wrapping at N-1.
  always_comb begin : p_ptr_nxt
    if (w_gidx == PW'(N - 1)) begin
      w_ptr_nxt = '0;
    end else begin
      w_ptr_nxt = w_gidx + 1'b1;
    end
  end

  // Slot storage, round-robin pointer and output-valid pipeline stage.
  always_ff @(posedge clk) begin : p_state
    if (rst) begin
      r_slot_v    <= '0;
      r_ptr       <= '0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < N; i++) begin
        r_slot_d[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          r_slot_v[i] <= 1'b1;
          r_slot_d[i] <= req_data[i];
        end else if (w_grant[i]) begin
          r_slot_v[i] <= 1'b0;
        end
      end
      if (|w_grant) begin
        r_ptr <= w_ptr_nxt;
      end
      r_out_valid <= |w_grant;
    end
  end

  // A granted slot frees up this cycle, so it can refill in the same edge.
  assign req_ready = rst ? '1 : (~r_slot_v | w_grant);
  assign mux_en    = w_grant;
  assign mux_in    = r_slot_d;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_onehot_rr_arbiter.sv
// Directed bench for onehot_rr_arbiter with a behavioural registered one-hot
// mux downstream, so grant order and delivered words can be checked together.
module tb_onehot_rr_arbiter;

  localparam int WIDTH = 16;
  localparam int N     = 3;

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [WIDTH-1:0] req_data [N-1:0];
  logic [N-1:0]     req_ready;
  logic             stall;
  logic [WIDTH-1:0] mux_in [N-1:0];
  logic [N-1:0]     mux_en;
  logic             out_valid;

  logic [WIDTH-1:0] mux_q;
  logic [WIDTH-1:0] mux_or;

  int checks = 0;
  int errors = 0;

  onehot_rr_arbiter #(.WIDTH(WIDTH), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .stall     (stall),
    .mux_in    (mux_in),
    .mux_en    (mux_en),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream one-hot registered mux: OR of enabled inputs, one cycle later.
  always_comb begin
    mux_or = '0;
    for (int i = 0; i < N; i++) begin
      if (mux_en[i]) mux_or = mux_or | mux_in[i];
    end
  end

  always @(posedge clk) mux_q <= mux_or;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [WIDTH-1:0] d0,
                       input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2);
    req_valid   = v;
    req_data[0] = d0;
    req_data[1] = d1;
    req_data[2] = d2;
    #1;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    drive(3'b111, 16'h1111, 16'h2222, 16'h3333);

    // Reset held two cycles with all sources offering
    tick();
    check("rst1_en", 32'(mux_en), 32'h0);
    check("rst1_ov", 32'(out_valid), 32'h0);
    tick();
    check("rst2_en", 32'(mux_en), 32'h0);
    check("rst2_ov", 32'(out_valid), 32'h0);
    check("rst2_rdy", 32'(req_ready), 32'h7);
    rst = 1'b0;
    drive(3'b000, 16'h0000, 16'h0000, 16'h0000);
    check("post_rst_en", 32'(mux_en), 32'h0);
    check("post_rst_rdy", 32'(req_ready), 32'h7);
    check("post_rst_in0", 32'(mux_in[0]), 32'h0);
    tick();
    check("post_rst_ov", 32'(out_valid), 32'h0);

    // Single source, no bypass into empty slot
    drive(3'b001, 16'hA5A5, 16'h0000, 16'h0000);
    check("single_nobypass", 32'(mux_en), 32'h0);
    tick();
    drive(3'b000, 16'h0000, 16'h0000, 16'h0000);
    check("single_en", 32'(mux_en), 32'h1);
    tick();
    check("single_ov", 32'(out_valid), 32'h1);
    check("single_q", 32'(mux_q), 32'hA5A5);
    check("single_idle", 32'(mux_en), 32'h0);
    check("single_ptr", 32'(dut.r_ptr), 32'h1);
    tick();
    check("single_ov_drop", 32'(out_valid), 32'h0);

    // Move ptr to 0 via slot2, then load all three
    drive(3'b100, 16'h0000, 16'h0000, 16'h7777);
    tick();
    drive(3'b000, 16'h0000, 16'h0000, 16'h0000);
    check("to0_en", 32'(mux_en), 32'h4);
    tick();
    check("to0_q", 32'(mux_q), 32'h7777);
    check("to0_ptr", 32'(dut.r_ptr), 32'h0);
    drive(3'b111, 16'h0001, 16'h0002, 16'h0003);
    tick();
    drive(3'b000, 16'h0000, 16'h0000, 16'h0000);
    check("all_g0", 32'(mux_en), 32'h1);
    tick();
    check("all_q0", 32'(mux_q), 32'h0001);
    check("all_g1", 32'(mux_en), 32'h2);
    tick();
    check("all_q1", 32'(mux_q), 32'h0002);
    check("all_g2", 32'(mux_en), 32'h4);
    tick();
    check("all_q2", 32'(mux_q), 32'h0003);
    check("all_ov", 32'(out_valid), 32'h1);
    check("all_idle", 32'(mux_en), 32'h0);

    // Wrap: grant slot1 while loading slots 0 and 2, leaving ptr=2
    drive(3'b010, 16'h0000, 16'h1111, 16'h0000);
    tick();
    drive(3'b101, 16'h4000, 16'h0000, 16'h4002);
    check("wrap_pre_g", 32'(mux_en), 32'h2);
    tick();
    drive(3'b000, 16'h0000, 16'h0000, 16'h0000);
    check("wrap_ptr2", 32'(dut.r_ptr), 32'h2);
    check("wrap_g2", 32'(mux_en), 32'h4);
    tick();
    check("wrap_q2", 32'(mux_q), 32'h4002);
    check("wrap_g0", 32'(mux_en), 32'h1);
    tick();
    check("wrap_q0", 32'(mux_q), 32'h4000);
    check("wrap_ptr1", 32'(dut.r_ptr), 32'h1);

    // Refill slot1 in the cycle it is granted
    drive(3'b011, 16'h0AAA, 16'h1234, 16'h0000);
    tick();
    drive(3'b010, 16'h0000, 16'hBEEF, 16'h0000);
    check("refill_g1", 32'(mux_en), 32'h2);
    check("refill_rdy", 32'(req_ready), 32'h6);
    tick();
    drive(3'b000, 16'h0000, 16'h0000, 16'h0000);
    check("refill_q", 32'(mux_q), 32'h1234);
    check("refill_v", 32'(dut.r_slot_v), 32'h3);
    check("refill_g0", 32'(mux_en), 32'h1);
    tick();
    check("refill_q0", 32'(mux_q), 32'h0AAA);
    check("refill_gb", 32'(mux_en), 32'h2);
    check("refill_in1", 32'(mux_in[1]), 32'hBEEF);
    tick();
    check("refill_qb", 32'(mux_q), 32'hBEEF);
    check("refill_ptr", 32'(dut.r_ptr), 32'h2);

    // Stall: empty slots accept, full slots hold, no grant for 3 cycles
    stall = 1'b1;
    drive(3'b111, 16'h6000, 16'h6001, 16'h6002);
    check("stall_load_en", 32'(mux_en), 32'h0);
    check("stall_load_rdy", 32'(req_ready), 32'h7);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("stall_en", 32'(mux_en), 32'h0);
      check("stall_rdy", 32'(req_ready), 32'h0);
      check("stall_ov", 32'(out_valid), 32'h0);
    end
    stall = 1'b0;
    drive(3'b000, 16'h0000, 16'h0000, 16'h0000);
    check("resume_g2", 32'(mux_en), 32'h4);
    tick();
    check("resume_q2", 32'(mux_q), 32'h6002);
    check("resume_g0", 32'(mux_en), 32'h1);
    tick();
    check("resume_q0", 32'(mux_q), 32'h6000);
    check("resume_g1", 32'(mux_en), 32'h2);

    // Reset mid-operation drops buffered words
    rst = 1'b1;
    #1;
    check("midrst_en", 32'(mux_en), 32'h0);
    check("midrst_rdy", 32'(req_ready), 32'h7);
    tick();
    rst = 1'b0;
    #1;
    check("midrst_v", 32'(dut.r_slot_v), 32'h0);
    check("midrst_ov", 32'(out_valid), 32'h0);
    check("midrst_ptr", 32'(dut.r_ptr), 32'h0);
    check("midrst_en2", 32'(mux_en), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
